// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format codes, opcode
// constants, the buffer-entry descriptor and a sign-extension helper.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Width-independent part of a buffer entry; the XLEN-wide immediate
    // travels alongside it in the buffer.
    typedef struct packed {
        logic       illegal;
        fmt_e       fmt;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-execute handshake bundle for imm_decode_stage.
// slave: the decode stage; master: the surrounding fetch/execute logic.
interface imm_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    import imm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_rd, out_rs1, out_rs2, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_rd, out_rs1, out_rs2, out_illegal
    );

endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational instruction classifier and immediate extractor.
// Optional macro IMM_DECODE_RVC_EN adds expansion of a subset of 16-bit
// compressed encodings; without it any non-32-bit encoding is illegal.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extract: XLEN must be 32 or 64");
    end

    // Format classification and immediate assembly; unknown encodings give FMT_ILL with imm 0.
    always_comb begin
        fmt = FMT_ILL;
        imm = '0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
                    fmt = FMT_I;
                    imm = XLEN'(sext(64'(instr[31:20]), 12));
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    imm = XLEN'(sext(64'({instr[31:25], instr[11:7]}), 12));
                end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    imm = XLEN'(sext(64'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13));
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt = FMT_U;
                    imm = XLEN'(sext(64'({instr[31:12], 12'b0}), 32));
                end
                OPC_JAL: begin
                    fmt = FMT_J;
                    imm = XLEN'(sext(64'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21));
                end
                OPC_OP: begin
                    fmt = FMT_R;
                end
                default: begin
                    fmt = FMT_ILL;
                end
            endcase
        end
`ifdef IMM_DECODE_RVC_EN
        else begin
            // Compressed: keyed on {funct3, quadrant}.
            case ({instr[15:13], instr[1:0]})
                5'b000_01, 5'b010_01: begin // C.ADDI, C.LI
                    fmt = FMT_I;
                    imm = XLEN'(sext(64'({instr[12], instr[6:2]}), 6));
                end
                5'b010_00: begin // C.LW
                    fmt = FMT_I;
                    imm = XLEN'(64'({instr[5], instr[12:10], instr[6], 2'b00}));
                end
                5'b110_00: begin // C.SW
                    fmt = FMT_S;
                    imm = XLEN'(64'({instr[5], instr[12:10], instr[6], 2'b00}));
                end
                5'b101_01: begin // C.J
                    fmt = FMT_J;
                    imm = XLEN'(sext(64'({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                          instr[2], instr[11], instr[5:3], 1'b0}), 12));
                end
                5'b110_01, 5'b111_01: begin // C.BEQZ, C.BNEZ
                    fmt = FMT_B;
                    imm = XLEN'(sext(64'({instr[12], instr[6:5], instr[2], instr[11:10],
                                          instr[4:3], 1'b0}), 9));
                end
                default: begin
                    fmt = FMT_ILL;
                end
            endcase
        end
`endif
    end

    assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: imm_extract feeding a 2-entry skid
// buffer with valid/ready on both sides. Optional macro IMM_DECODE_RVC_EN
// (see imm_extract) enables compressed-instruction decode.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    imm_decode_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (DEPTH != 2) begin : g_bad_depth
        $error("imm_decode_stage: DEPTH is fixed at 2");
    end

    fmt_e            x_fmt;
    logic [XLEN-1:0] x_imm;
    logic            x_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (bus.in_instr),
        .fmt     (x_fmt),
        .imm     (x_imm),
        .illegal (x_illegal)
    );

    dec_t            new_ent;
    dec_t            ent_q [2];
    dec_t            ent_d [2];
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] imm_d [2];
    logic [1:0]      count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            push, pop;

    assign new_ent = '{illegal: x_illegal, fmt: x_fmt, rd: bus.in_instr[11:7],
                       rs1: bus.in_instr[19:15], rs2: bus.in_instr[24:20]};

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    // Buffer update: slot 0 is always the head; a pop shifts slot 1 forward.
    always_comb begin
        ent_d   = ent_q;
        imm_d   = imm_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent_d[0] = new_ent;
                    imm_d[0] = x_imm;
                end else begin
                    ent_d[1] = new_ent;
                    imm_d[1] = x_imm;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent_d[0] = ent_q[1];
                imm_d[0] = imm_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; new entry lands behind whatever remains.
                if (count_q == 2'd1) begin
                    ent_d[0] = new_ent;
                    imm_d[0] = x_imm;
                end else begin
                    ent_d[0] = ent_q[1];
                    imm_d[0] = imm_q[1];
                    ent_d[1] = new_ent;
                    imm_d[1] = x_imm;
                end
            end
            default: ;
        endcase
        in_ready_d = (count_d < 2'd2);
    end

    // State registers; reset discards all buffered entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            in_ready_q <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            ent_q      <= ent_d;
            imm_q      <= imm_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.out_imm     = imm_q[0];
    assign bus.out_fmt     = ent_q[0].fmt;
    assign bus.out_rd      = ent_q[0].rd;
    assign bus.out_rs1     = ent_q[0].rs1;
    assign bus.out_rs2     = ent_q[0].rs2;
    assign bus.out_illegal = ent_q[0].illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in
// lockstep, checked against a queue-based reference model.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) bus32 ();
    imm_decode_stage_if #(.XLEN(64)) bus64 ();

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of a w-bit two's-complement field, as a 64-bit pattern.
    function automatic logic [63:0] sx(input longint unsigned v, input int w);
        longint s;
        s = longint'(v);
        if (((v >> (w - 1)) & 1) != 0) s = s - (longint'(1) << w);
        return s;
    endfunction

    // Reference decode written straight from the opcode/immediate tables.
    task automatic ref_dec(input logic [31:0] ins, output fmt_e f, output logic [63:0] imm);
        longint unsigned v;
        f   = FMT_ILL;
        imm = '0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                f = FMT_I; imm = sx(ins >> 20, 12);
            end
            7'b0100011: begin
                v = (ins >> 25) * 32 + ((ins >> 7) & 31);
                f = FMT_S; imm = sx(v, 12);
            end
            7'b1100011: begin
                v = ins[31] * 4096 + ins[7] * 2048 + ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2;
                f = FMT_B; imm = sx(v, 13);
            end
            7'b0110111, 7'b0010111: begin
                v = (ins >> 12) * 4096;
                f = FMT_U; imm = sx(v, 32);
            end
            7'b1101111: begin
                v = ins[31] * (1 << 20) + ((ins >> 12) & 255) * (1 << 12) + ins[20] * 2048
                    + ((ins >> 21) & 1023) * 2;
                f = FMT_J; imm = sx(v, 21);
            end
            7'b0110011: f = FMT_R;
            default: f = FMT_ILL;
        endcase
`ifdef IMM_DECODE_RVC_EN
        if (ins[1:0] != 2'b11) begin
            f   = FMT_ILL;
            imm = '0;
            if (ins[1:0] == 2'b01 && (ins[15:13] == 3'd0 || ins[15:13] == 3'd2)) begin
                f = FMT_I; imm = sx(ins[12] * 32 + ((ins >> 2) & 31), 6);
            end else if (ins[1:0] == 2'b00 && (ins[15:13] == 3'd2 || ins[15:13] == 3'd6)) begin
                f   = (ins[15:13] == 3'd2) ? FMT_I : FMT_S;
                imm = ins[5] * 64 + ((ins >> 10) & 7) * 8 + ins[6] * 4;
            end else if (ins[1:0] == 2'b01 && ins[15:13] == 3'd5) begin
                v = ins[12] * 2048 + ins[8] * 1024 + ((ins >> 9) & 3) * 256 + ins[6] * 128
                    + ins[7] * 64 + ins[2] * 32 + ins[11] * 16 + ((ins >> 3) & 7) * 2;
                f = FMT_J; imm = sx(v, 12);
            end else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) begin
                v = ins[12] * 256 + ((ins >> 5) & 3) * 64 + ins[2] * 32 + ((ins >> 10) & 3) * 8
                    + ((ins >> 3) & 3) * 2;
                f = FMT_B; imm = sx(v, 9);
            end
        end
`endif
    endtask

    task automatic check_head(input logic [31:0] ins);
        fmt_e        f;
        logic [63:0] imm;
        ref_dec(ins, f, imm);
        chk("imm32",   bus32.out_imm, imm & 64'hFFFF_FFFF);
        chk("imm64",   bus64.out_imm, imm);
        chk("fmt",     bus32.out_fmt, f);
        chk("fmt64",   bus64.out_fmt, f);
        chk("illegal", bus32.out_illegal, (f == FMT_ILL));
        chk("rd",      bus32.out_rd,  (ins >> 7) & 31);
        chk("rs1",     bus32.out_rs1, (ins >> 15) & 31);
        chk("rs2",     bus32.out_rs2, (ins >> 20) & 31);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, output bit acc);
        bit exp_rdy, exp_vld;
        bus32.in_valid = v;   bus32.in_instr = ins; bus32.out_ready = rdy;
        bus64.in_valid = v;   bus64.in_instr = ins; bus64.out_ready = rdy;
        #1;
        exp_rdy = (q.size() < 2);
        exp_vld = (q.size() > 0);
        chk("in_ready",    bus32.in_ready,  exp_rdy);
        chk("out_valid",   bus32.out_valid, exp_vld);
        chk("in_ready64",  bus64.in_ready,  exp_rdy);
        chk("out_valid64", bus64.out_valid, exp_vld);
        if (exp_vld) check_head(q[0]);
        acc = v && exp_rdy;
        if (exp_vld && rdy) void'(q.pop_front());
        if (acc) q.push_back(ins);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [31:0] ins, input fmt_e f,
                            input logic [63:0] imm64, input logic [4:0] rd, input logic [4:0] rs2);
        bit acc;
        cycle(1'b1, ins, 1'b1, acc);
        #1;
        chk({tag, "_valid"}, bus32.out_valid, 1'b1);
        chk({tag, "_fmt"},   bus32.out_fmt, f);
        chk({tag, "_imm32"}, bus32.out_imm, imm64 & 64'hFFFF_FFFF);
        chk({tag, "_imm64"}, bus64.out_imm, imm64);
        chk({tag, "_ill"},   bus32.out_illegal, (f == FMT_ILL));
        chk({tag, "_rd"},    bus32.out_rd, rd);
        chk({tag, "_rs2"},   bus32.out_rs2, rs2);
        cycle(1'b0, 32'h0, 1'b1, acc);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
        logic [31:0] r;
        int unsigned sel;
        r   = $urandom;
        sel = $urandom_range(0, 12);
        if (sel < 11) r[6:0] = opc[sel];
        return r;
    endfunction

    initial begin
        bit acc;
        int idx;
        logic [31:0] s4 [4];

        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus32.out_valid, 1'b0);
        chk("rst_in_ready",  bus32.in_ready, 1'b1);
        chk("rst_imm",       bus64.out_imm, 64'h0);
        chk("rst_fmt",       bus32.out_fmt, FMT_R);
        chk("rst_rd",        bus32.out_rd, 5'd0);
        chk("rst_rs1",       bus32.out_rs1, 5'd0);
        chk("rst_rs2",       bus32.out_rs2, 5'd0);
        chk("rst_illegal",   bus32.out_illegal, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        directed("lw",   32'h0000_2083, FMT_I,   64'h0,                   5'd1,  5'd0);
        directed("sw",   32'h3E10_2FA3, FMT_S,   64'h3FF,                 5'd31, 5'd1);
        directed("beq",  32'hFE00_0FE3, FMT_B,   64'hFFFF_FFFF_FFFF_FFFE, 5'd31, 5'd0);
        directed("lui",  32'h8000_00B7, FMT_U,   64'hFFFF_FFFF_8000_0000, 5'd1,  5'd0);
        directed("ill",  32'h0000_007F, FMT_ILL, 64'h0,                   5'd0,  5'd0);
`ifdef IMM_DECODE_RVC_EN
        directed("cnop", 32'h0000_0001, FMT_I,   64'h0,                   5'd0,  5'd0);
`else
        directed("cnop", 32'h0000_0001, FMT_ILL, 64'h0,                   5'd0,  5'd0);
`endif

        // Back-pressure: consumer stalls for the first three cycles.
        s4[0] = 32'h0040_0093; s4[1] = 32'hFFF0_0113; s4[2] = 32'h0000_0FB7; s4[3] = 32'h0080_006F;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            if (c == 2) begin
                #1;
                chk("stream_full", bus32.in_ready, 1'b0);
            end
            cycle(1'b1, s4[idx], (c >= 3), acc);
            if (acc) idx++;
        end
        chk("stream_accepted", idx, 4);
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 1'b1, acc);

        // Reset with two entries held.
        cycle(1'b1, 32'h0010_0093, 1'b0, acc);
        cycle(1'b1, 32'h0020_0113, 1'b0, acc);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", bus32.out_valid, 1'b0);
        chk("midrst_in_ready",  bus32.in_ready, 1'b1);
        chk("midrst_valid64",   bus64.out_valid, 1'b0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 32'h0030_01A3, 1'b1, acc);
        #1;
        chk("postrst_rs2", bus32.out_rs2, 5'd3);
        cycle(1'b0, 32'h0, 1'b1, acc);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0), acc);
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 1'b1, acc);
        chk("drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
